pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register. It generalises the fixed IF/ID latch into a reusable stage for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a DATA_W-bit instruction packet with a valid/ready handshake, backed by a 2-entry skid buffer so that ready is registered.
- Supports flush (bubble insertion) and extracts the register-specifier fields (sr1, sr2, dr) for hazard detection and forwarding in the downstream stage.

Parameters:
- DATA_W, 64, packet width in bits.
- REG_W, 3, register specifier width.
- SR1_LSB, 0, bit offset of sr1 within the packet.
- SR2_LSB, 3, bit offset of sr2 within the packet.
- DR_LSB, 6, bit offset of dr within the packet.
- CNT_W, 16, perf counter width (only used with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held packets this cycle.
- in_valid  in  1  upstream packet valid.
- in_data  in  DATA_W  upstream packet.
- in_ready  out  1  stage can accept a packet; driven directly from a register.
- out_valid  out  1  out_data valid.
- out_data  out  DATA_W  packet to the next stage.
- out_ready  in  1  downstream accepts the packet.
- sr1  out  REG_W  out_data[SR1_LSB +: REG_W].
- sr2  out  REG_W  out_data[SR2_LSB +: REG_W].
- dr  out  REG_W  out_data[DR_LSB +: REG_W].
- stall_cnt  out  CNT_W  present only with PIPE_STAGE_PERF_EN.
- bubble_cnt  out  CNT_W  present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Storage is a main register (out_data/out_valid) plus a skid register (skid_data/skid_valid).
- State is encoded by the valid bits:
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - FULL: main=1, skid=1.
- Accept condition: acc = in_valid & in_ready.
- Drain condition: drn = out_valid & out_ready.
- Reset (synchronous): out_valid=0, skid_valid=0, out_data=0, skid_data=0, in_ready=1, counters=0. Reset in the middle of traffic discards everything on that edge.
- in_ready equals ~skid_valid as registered state. There is no combinational path from out_ready to in_ready.
- Latency: a packet accepted at edge N appears on out_data/out_valid after edge N (1 cycle).
- Transitions (flush=0):
  - EMPTY, acc: load main -> ONE.
  - ONE, acc & drn: main <= in_data, stay ONE.
  - ONE, acc & ~drn: skid <= in_data -> FULL. in_ready falls next cycle.
  - ONE, ~acc & drn: -> EMPTY.
  - ONE, ~acc & ~drn: hold.
  - FULL, drn: main <= skid, skid_valid=0 -> ONE.
  - FULL, ~drn: hold all.
  - acc cannot occur in FULL because in_ready=0.
- Flush = 1:
  - Next state EMPTY; out_valid=0 and skid_valid=0.
  - Overrides a simultaneous acc: the incoming packet is dropped and not loaded.
  - A simultaneous drn still completes downstream this cycle.
  - in_ready=1 next cycle.
  - Data registers may retain stale values; consumers qualify with out_valid.
- Ordering: packets leave in acceptance order and none are duplicated.
- out_data, out_valid and the sr/dr fields are stable while out_valid & ~out_ready. Field extraction is purely combinational from out_data.
- Reset has priority over flush; flush has priority over all handshake events.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - bubble_cnt increments each cycle with ~out_valid & ~flush.
  - Both saturate at all-ones and clear on reset.
- Undefined: stall_cnt, bubble_cnt and their logic are absent from the port list and RTL; behaviour is otherwise identical.

Test Plan:
- Reset, then in_valid=1, in_data=64'h1C5 (sr1=5, sr2=0, dr=7) with out_ready=1 -> one cycle later out_valid=1, out_data=64'h1C5, sr1=5, dr=7, in_ready=1.
- Streaming: present packets A,B,C on consecutive cycles with out_ready=1 -> A,B,C appear on consecutive cycles, no gaps, in_ready held 1.
- Backpressure: out_ready=0, send A then B -> out_data holds A, skid holds B, in_ready=0 next cycle. Raise out_ready -> A, then B, then in_ready=1.
- Flush in FULL with in_valid=1 carrying D -> next cycle out_valid=0, in_ready=1; D never appears; A/B are not emitted afterwards.
- Reset asserted while FULL with out_ready=0 -> next cycle out_valid=0, out_data=0, in_ready=1; first post-reset packet appears 1 cycle after acceptance.
- With PIPE_STAGE_PERF_EN and CNT_W=2: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=3 (saturated); 2 idle unflushed cycles after reset -> bubble_cnt=2.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer, a registered ready and flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int DATA_W  = 64,
  parameter int REG_W   = 3,
  parameter int SR1_LSB = 0,
  parameter int SR2_LSB = 3,
  parameter int DR_LSB  = 6,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [REG_W-1:0]  sr1,
  output logic [REG_W-1:0]  sr2,
  output logic [REG_W-1:0]  dr
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Handshake: a packet moves on any rising edge where valid & ready are both high;
  // the sender must hold valid and data stable until that edge, and ready never
  // depends combinationally on valid or on the downstream ready.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              out_valid_nxt;
  logic              skid_valid_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic [DATA_W-1:0] skid_data_nxt;
  logic              acc;
  logic              drn;

  assign state = state_t'({skid_valid, out_valid});
  assign acc   = in_valid & in_ready;
  assign drn   = out_valid & out_ready;

  always_comb begin
    out_valid_nxt  = out_valid;
    skid_valid_nxt = skid_valid;
    out_data_nxt   = out_data;
    skid_data_nxt  = skid_data;
    if (flush) begin
      // Data registers keep stale contents; only the valid bits are cleared.
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            out_data_nxt  = in_data;
            out_valid_nxt = 1'b1;
          end
        end
        ONE: begin
          if (acc && drn) begin
            out_data_nxt = in_data;
          end else if (acc) begin
            skid_data_nxt  = in_data;
            skid_valid_nxt = 1'b1;
          end else if (drn) begin
            out_valid_nxt = 1'b0;
          end
        end
        FULL: begin
          if (drn) begin
            out_data_nxt   = skid_data;
            skid_valid_nxt = 1'b0;
          end
        end
        default: begin
          out_valid_nxt  = 1'b0;
          skid_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= out_valid_nxt;
      skid_valid <= skid_valid_nxt;
      out_data   <= out_data_nxt;
      skid_data  <= skid_data_nxt;
      in_ready   <= ~skid_valid_nxt;
    end
  end

  assign sr1 = out_data[SR1_LSB +: REG_W];
  assign sr2 = out_data[SR2_LSB +: REG_W];
  assign dr  = out_data[DR_LSB  +: REG_W];

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!out_valid && !flush && !(&bubble_cnt)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, then random traffic against a queue model.
module tb_pipe_stage_reg;
  localparam int DATA_W = 64;
  localparam int REG_W  = 3;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [REG_W-1:0]  sr1;
  logic [REG_W-1:0]  sr2;
  logic [REG_W-1:0]  dr;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  pipe_stage_reg #(
    .DATA_W(DATA_W), .REG_W(REG_W), .SR1_LSB(0), .SR2_LSB(3), .DR_LSB(6), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sr1(sr1), .sr2(sr2), .dr(dr)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: packets currently held by the stage, oldest first.
  logic [DATA_W-1:0] exp_q[$];
`ifdef PIPE_STAGE_PERF_EN
  int stall_m  = 0;
  int bubble_m = 0;
`endif

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_fields(input string tag, input logic [DATA_W-1:0] pkt);
    logic [DATA_W-1:0] p;
    p = pkt;
    check({tag, " sr1"}, DATA_W'(sr1), DATA_W'(p[2:0]));
    check({tag, " sr2"}, DATA_W'(sr2), DATA_W'(p[5:3]));
    check({tag, " dr"},  DATA_W'(dr),  DATA_W'(p[8:6]));
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [DATA_W-1:0] d, input logic ordy);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  typedef struct {
    logic              rst;
    logic              fl;
    logic              iv;
    logic [DATA_W-1:0] d;
    logic              ordy;
    logic              exp_v;
    logic              exp_r;
    logic              chk_d;
    logic [DATA_W-1:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic [DATA_W-1:0] d, input logic ordy,
                              input logic ev, input logic er, input logic cd,
                              input logic [DATA_W-1:0] ed);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.exp_v = ev; v.exp_r = er; v.chk_d = cd; v.exp_d = ed;
    return v;
  endfunction

  // One random/modelled cycle: model advances on the same edge as the DUT.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [DATA_W-1:0] d, input logic ordy);
    logic acc, drn, m_valid;
    drive(rst, fl, iv, d, ordy);
    m_valid = (exp_q.size() > 0);
    acc = iv && (exp_q.size() < 2);
    drn = m_valid && ordy;
    @(posedge clk);
    if (rst || fl) begin
      exp_q.delete();
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(d);
    end
`ifdef PIPE_STAGE_PERF_EN
    if (rst) begin
      stall_m = 0; bubble_m = 0;
    end else begin
      if (m_valid && !ordy && stall_m < (1 << CNT_W) - 1) stall_m++;
      if (!m_valid && !fl && bubble_m < (1 << CNT_W) - 1) bubble_m++;
    end
`endif
    #1;
    check("rnd out_valid", DATA_W'(out_valid), DATA_W'(exp_q.size() > 0));
    check("rnd in_ready",  DATA_W'(in_ready),  DATA_W'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      check("rnd out_data", out_data, exp_q[0]);
      check_fields("rnd", exp_q[0]);
    end
`ifdef PIPE_STAGE_PERF_EN
    check("rnd stall_cnt",  DATA_W'(stall_cnt),  DATA_W'(stall_m));
    check("rnd bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(bubble_m));
`endif
  endtask

  localparam logic [DATA_W-1:0] PA = 64'hA5A5_0000_0000_0111;
  localparam logic [DATA_W-1:0] PB = 64'hB0B0_1111_2222_0222;
  localparam logic [DATA_W-1:0] PC = 64'hC3C3_DEAD_BEEF_0133;
  localparam logic [DATA_W-1:0] PD = 64'hD00D_0000_0000_01FF;
  localparam logic [DATA_W-1:0] PE = 64'hE1E1_0000_1234_0055;

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);

    //            rst fl iv data    ordy  ev  er  chk data
    vecs.push_back(mk(1, 0, 0, '0,      0,  0,  1,  1, '0));
    vecs.push_back(mk(0, 0, 1, 64'h1C5, 1,  1,  1,  1, 64'h1C5));
    vecs.push_back(mk(0, 0, 1, PA,      1,  1,  1,  1, PA));
    vecs.push_back(mk(0, 0, 1, PB,      1,  1,  1,  1, PB));
    vecs.push_back(mk(0, 0, 1, PC,      1,  1,  1,  1, PC));
    vecs.push_back(mk(0, 0, 0, '0,      1,  0,  1,  0, '0));
    // backpressure: A in main, B in skid, D refused while full
    vecs.push_back(mk(0, 0, 1, PA,      0,  1,  1,  1, PA));
    vecs.push_back(mk(0, 0, 1, PB,      0,  1,  0,  1, PA));
    vecs.push_back(mk(0, 0, 1, PD,      0,  1,  0,  1, PA));
    vecs.push_back(mk(0, 0, 0, '0,      1,  1,  1,  1, PB));
    vecs.push_back(mk(0, 0, 0, '0,      1,  0,  1,  0, '0));
    // flush while full with D offered
    vecs.push_back(mk(0, 0, 1, PA,      0,  1,  1,  1, PA));
    vecs.push_back(mk(0, 0, 1, PB,      0,  1,  0,  1, PA));
    vecs.push_back(mk(0, 1, 1, PD,      0,  0,  1,  0, '0));
    vecs.push_back(mk(0, 0, 0, '0,      1,  0,  1,  0, '0));
    vecs.push_back(mk(0, 0, 0, '0,      1,  0,  1,  0, '0));
    // reset while full
    vecs.push_back(mk(0, 0, 1, PA,      0,  1,  1,  1, PA));
    vecs.push_back(mk(0, 0, 1, PB,      0,  1,  0,  1, PA));
    vecs.push_back(mk(1, 0, 0, '0,      0,  0,  1,  1, '0));
    vecs.push_back(mk(0, 0, 1, PE,      0,  1,  1,  1, PE));
    vecs.push_back(mk(0, 0, 0, '0,      1,  0,  1,  0, '0));
    // flush with a simultaneous drain and offered packet
    vecs.push_back(mk(0, 0, 1, PC,      1,  1,  1,  1, PC));
    vecs.push_back(mk(0, 1, 1, PD,      1,  0,  1,  0, '0));
    vecs.push_back(mk(0, 0, 0, '0,      1,  0,  1,  0, '0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), DATA_W'(out_valid), DATA_W'(vecs[i].exp_v));
      check($sformatf("vec%0d in_ready", i),  DATA_W'(in_ready),  DATA_W'(vecs[i].exp_r));
      if (vecs[i].chk_d) begin
        check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_d);
        if (vecs[i].exp_v) check_fields($sformatf("vec%0d", i), vecs[i].exp_d);
      end
    end

    // Hand sequence: a stalled packet stays stable for several cycles.
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h1C5, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1, PC, 1'b0);
      check("stall hold data", out_data, 64'h1C5);
    end
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("stall release data", out_data, PC);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Random traffic with occasional flush and rare reset.
    for (int n = 0; n < 3000; n++) begin
      logic r, f, v, o;
      logic [DATA_W-1:0] d;
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      d = {$urandom, $urandom};
      step(r, f, v, d, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
